wb_axil_pipelined_bridge: RTL and testbench
===========================================

// Module: wb_axil_pipelined_bridge
// PURPOSE
//  Pipelined Wishbone (B4) slave to AXI4-Lite master bridge. Next-generation successor to the single-shot bridge.
//  Keeps up to MAX_OUTSTANDING same-direction transactions in flight, with independent AW/W handshakes.
//  Adds a response timeout that converts a hung AXI slave into WB_ERR pulses. Sits between the Wishbone
//  interconnect and AXI4-Lite register banks.
// PARAMETERS
//  ADDR_WIDTH      32   WB/AXI address width
//  DATA_WIDTH      32   data width; multiple of 8
//  AXI_BASE_ADDR   0    subtracted from WB_ADDR before shifting
//  ADDR_SHIFT      2    right shift applied after subtraction (0 = byte addressing passthrough)
//  MAX_OUTSTANDING 4    in-flight limit, 1..16
//  TIMEOUT_CYCLES  1024 idle-response cycles before abort; 0 disables the timeout
// PORTS
//  CLK          in  1            clock
//  RST          in  1            synchronous reset, active-high
//  WB_CYC/WB_STB/WB_WE in 1 each Wishbone cycle, strobe, write-enable
//  WB_ADDR      in  ADDR_WIDTH   byte address
//  WB_WDATA     in  DATA_WIDTH   write data
//  WB_SEL       in  DATA_WIDTH/8 byte selects -> AXI_WSTRB
//  WB_STALL     out 1            request not accepted this cycle
//  WB_ACK       out 1            one-cycle completion pulse, OKAY/EXOKAY
//  WB_ERR       out 1            one-cycle completion pulse, SLVERR/DECERR/timeout
//  WB_RDATA     out DATA_WIDTH   registered read data, valid with WB_ACK
//  AXI_AW*/W*/B*/AR*/R*  AXI4-Lite master channels; AWPROT/ARPROT tied 3'b000
//  OUTSTANDING  out $clog2(MAX_OUTSTANDING+1)  in-flight count
//  TIMEOUT_FLAG out 1            sticky; set on any timeout, cleared only by RST
// BEHAVIOUR
//  Reset: all VALIDs, WB_ACK, WB_ERR, WB_STALL, OUTSTANDING, TIMEOUT_FLAG = 0; WB_RDATA = 0. BREADY = RREADY = 1 always.
//  Accept: WB_CYC & WB_STB & !WB_STALL in cycle t.
//   Address, data and strobe are registered. The relevant VALIDs rise at t+1.
//   Address = (WB_ADDR - AXI_BASE_ADDR) >> ADDR_SHIFT, modulo 2^ADDR_WIDTH.
//  AW and W are held independently until their own READY. They may complete in either order or in the same cycle.
//  WB_STALL = AWVALID | WVALID | ARVALID | (OUTSTANDING==MAX_OUTSTANDING) | (OUTSTANDING!=0 & WB_WE!=dir) | abort.
//   dir = direction of the in-flight transactions. Reads and writes are never mixed, so response order equals
//   request order.
//  OUTSTANDING: +1 on accept, -1 on BVALID or RVALID. Accept and response in the same cycle leave it unchanged.
//  Response in cycle r -> WB_ACK or WB_ERR at r+1. RDATA is latched at r. WB_ERR iff RESP[1]. ACK and ERR are never
//   both high.
//  If WB_CYC=0 at r, the response is consumed and the count decremented, but no ACK/ERR is emitted (abandoned cycle).
//  A response arriving with OUTSTANDING==0 (late, after abort) is dropped silently.
//  Timeout timer: counts while OUTSTANDING!=0. Cleared on every response and on every accept.
//   Reaching TIMEOUT_CYCLES enters ABORT. States: IDLE -> BUSY (count>0) -> ABORT -> IDLE.
//   ABORT: drop all VALIDs and stall. Emit one WB_ERR per outstanding entry on consecutive cycles
//    (suppressed if WB_CYC=0), decrementing to 0, then set TIMEOUT_FLAG and return to IDLE.
//  RST mid-transaction: immediate return to reset values. Pending AXI responses are afterwards treated as late
//   and dropped.
// TESTING
//  Single write 0x0000_0010 / 0xDEADBEEF, SEL=4'hF, AW/W ready same cycle ->
//   AWADDR=0x4, WSTRB=F, ACK 1 cycle after BVALID.
//  AWREADY at t+1, WREADY at t+4 -> AWVALID drops t+2, WVALID held to t+4, single ACK after BVALID.
//  4 back-to-back reads, slave RVALIDs 0xA0..0xA3 -> no stall until count=4, four ACKs in order with matching RDATA.
//  Write issued while 2 reads in flight -> stalled until OUTSTANDING=0, then accepted.
//  BRESP=2'b10 -> WB_ERR pulse, WB_ACK low.
//  TIMEOUT_CYCLES=16, 3 reads, slave silent -> 3 consecutive WB_ERR at cycle 16+, OUTSTANDING=0, TIMEOUT_FLAG=1.
//   A later RVALID is ignored.

Source files
------------

// File: rtl/wb_axil_pipelined_bridge.sv
// wb_axil_pipelined_bridge
// Pipelined Wishbone B4 slave to AXI4-Lite master bridge. It keeps up to
// MAX_OUTSTANDING transactions of one direction in flight. AW and W complete
// their handshakes independently. A response timeout retires hung entries as
// WB_ERR pulses.
//
// Ports
//   CLK, RST      clock, synchronous active-high reset
//   WB_*          Wishbone pipelined slave: CYC/STB/WE/ADDR/WDATA/SEL in,
//                 STALL/ACK/ERR/RDATA out
//   AXI_*         AXI4-Lite master: AW, W, B, AR and R channels
//   OUTSTANDING   number of accepted requests still waiting for a response
//   TIMEOUT_FLAG  sticky; set when a timeout abort completes
//
// state | meaning
// IDLE  | nothing in flight
// BUSY  | one or more requests in flight, timeout timer counting down
// ABORT | slave timed out; one WB_ERR issued per in-flight entry
module wb_axil_pipelined_bridge #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] AXI_BASE_ADDR   = '0,
  parameter int                    ADDR_SHIFT      = 2,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter int                    TIMEOUT_CYCLES  = 1024
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 WB_CYC,
  input  logic                                 WB_STB,
  input  logic                                 WB_WE,
  input  logic [ADDR_WIDTH-1:0]                WB_ADDR,
  input  logic [DATA_WIDTH-1:0]                WB_WDATA,
  input  logic [DATA_WIDTH/8-1:0]              WB_SEL,
  output logic                                 WB_STALL,
  output logic                                 WB_ACK,
  output logic                                 WB_ERR,
  output logic [DATA_WIDTH-1:0]                WB_RDATA,
  output logic [ADDR_WIDTH-1:0]                AXI_AWADDR,
  output logic [2:0]                           AXI_AWPROT,
  output logic                                 AXI_AWVALID,
  input  logic                                 AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]                AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]              AXI_WSTRB,
  output logic                                 AXI_WVALID,
  input  logic                                 AXI_WREADY,
  input  logic [1:0]                           AXI_BRESP,
  input  logic                                 AXI_BVALID,
  output logic                                 AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]                AXI_ARADDR,
  output logic [2:0]                           AXI_ARPROT,
  output logic                                 AXI_ARVALID,
  input  logic                                 AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]                AXI_RDATA,
  input  logic [1:0]                           AXI_RRESP,
  input  logic                                 AXI_RVALID,
  output logic                                 AXI_RREADY,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] OUTSTANDING,
  output logic                                 TIMEOUT_FLAG
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_t;

  state_t                  state_q, state_d;
  logic                    aw_valid_q, aw_valid_d;
  logic                    w_valid_q, w_valid_d;
  logic                    ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    dir_q, dir_d;        // 1 = writes in flight
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    timeout_flag_q, timeout_flag_d;

  logic                    stall;
  logic                    accept;
  logic                    resp_fire;
  logic                    resp_err;
  logic                    timeout_hit;
  logic [ADDR_WIDTH-1:0]   addr_xlat;
  logic                    unused_resp_lsb;

  // Only RESP[1] separates OKAY/EXOKAY from SLVERR/DECERR.
  assign unused_resp_lsb = AXI_BRESP[0] ^ AXI_RRESP[0];

  always_comb begin
    stall = aw_valid_q | w_valid_q | ar_valid_q | (cnt_q == CNT_MAX)
          | ((cnt_q != '0) & (WB_WE != dir_q)) | (state_q == S_ABORT);
    accept    = WB_CYC & WB_STB & ~stall;
    addr_xlat = (WB_ADDR - AXI_BASE_ADDR) >> ADDR_SHIFT;
    // Only the direction in flight can answer; anything with nothing
    // outstanding (late reply after abort or reset) is dropped.
    resp_fire = (dir_q ? AXI_BVALID : AXI_RVALID) & (cnt_q != '0) & (state_q != S_ABORT);
    resp_err  = dir_q ? AXI_BRESP[1] : AXI_RRESP[1];
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == S_BUSY) && !accept && !resp_fire
                  && (timer_q == TW'(1));

    state_d        = state_q;
    aw_valid_d     = aw_valid_q & ~AXI_AWREADY;
    w_valid_d      = w_valid_q & ~AXI_WREADY;
    ar_valid_d     = ar_valid_q & ~AXI_ARREADY;
    awaddr_d       = awaddr_q;
    araddr_d       = araddr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    rdata_d        = rdata_q;
    ack_d          = 1'b0;
    err_d          = 1'b0;
    dir_d          = dir_q;
    cnt_d          = cnt_q;
    timer_d        = timer_q;
    timeout_flag_d = timeout_flag_q;

    if (accept) begin
      dir_d = WB_WE;
      if (WB_WE) begin
        aw_valid_d = 1'b1;
        w_valid_d  = 1'b1;
        awaddr_d   = addr_xlat;
        wdata_d    = WB_WDATA;
        wstrb_d    = WB_SEL;
      end else begin
        ar_valid_d = 1'b1;
        araddr_d   = addr_xlat;
      end
    end

    if (accept && !resp_fire)      cnt_d = cnt_q + CW'(1);
    else if (!accept && resp_fire) cnt_d = cnt_q - CW'(1);

    // Abandoned cycles still consume the response, they just stay silent.
    if (resp_fire && WB_CYC) begin
      ack_d = ~resp_err;
      err_d = resp_err;
    end
    if (resp_fire && !dir_q) rdata_d = AXI_RDATA;

    if (accept || resp_fire)                       timer_d = TMO_LOAD;
    else if (state_q == S_BUSY && timer_q != '0)   timer_d = timer_q - TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (cnt_d != '0) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (timeout_hit) begin
          state_d    = S_ABORT;
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b0;
          ar_valid_d = 1'b0;
        end else if (cnt_d == '0) begin
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        ar_valid_d = 1'b0;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          err_d = WB_CYC;
        end
        if (cnt_q <= CW'(1)) begin
          state_d        = S_IDLE;
          timeout_flag_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      aw_valid_q     <= 1'b0;
      w_valid_q      <= 1'b0;
      ar_valid_q     <= 1'b0;
      awaddr_q       <= '0;
      araddr_q       <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      rdata_q        <= '0;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
      dir_q          <= 1'b0;
      cnt_q          <= '0;
      timer_q        <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      aw_valid_q     <= aw_valid_d;
      w_valid_q      <= w_valid_d;
      ar_valid_q     <= ar_valid_d;
      awaddr_q       <= awaddr_d;
      araddr_q       <= araddr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      rdata_q        <= rdata_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
      dir_q          <= dir_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign WB_STALL     = stall;
  assign WB_ACK       = ack_q;
  assign WB_ERR       = err_q;
  assign WB_RDATA     = rdata_q;
  assign AXI_AWADDR   = awaddr_q;
  assign AXI_AWPROT   = 3'b000;
  assign AXI_AWVALID  = aw_valid_q;
  assign AXI_WDATA    = wdata_q;
  assign AXI_WSTRB    = wstrb_q;
  assign AXI_WVALID   = w_valid_q;
  assign AXI_BREADY   = 1'b1;
  assign AXI_ARADDR   = araddr_q;
  assign AXI_ARPROT   = 3'b000;
  assign AXI_ARVALID  = ar_valid_q;
  assign AXI_RREADY   = 1'b1;
  assign OUTSTANDING  = cnt_q;
  assign TIMEOUT_FLAG = timeout_flag_q;

endmodule

// File: tb/tb_wb_axil_pipelined_bridge.sv
// Directed testbench for wb_axil_pipelined_bridge (TIMEOUT_CYCLES = 16).
module tb_wb_axil_pipelined_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_addr, wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_stall, wb_ack, wb_err;
  logic [31:0] wb_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [2:0]  outstanding;
  logic        timeout_flag;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_axil_pipelined_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_BASE_ADDR(32'h0), .ADDR_SHIFT(2),
    .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(clk), .RST(rst),
    .WB_CYC(wb_cyc), .WB_STB(wb_stb), .WB_WE(wb_we), .WB_ADDR(wb_addr),
    .WB_WDATA(wb_wdata), .WB_SEL(wb_sel), .WB_STALL(wb_stall), .WB_ACK(wb_ack),
    .WB_ERR(wb_err), .WB_RDATA(wb_rdata),
    .AXI_AWADDR(awaddr), .AXI_AWPROT(awprot), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARPROT(arprot), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready),
    .OUTSTANDING(outstanding), .TIMEOUT_FLAG(timeout_flag)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel);
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_addr  = addr;
    wb_wdata = data;
    wb_sel   = sel;
  endtask

  // Holds the request until it is accepted (bounded); afterwards the bench is
  // in the cycle right after the accepting edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (!wb_stall) ok = 1'b1;
      step();
    end
    wb_stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0; wb_sel = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    step(); step(); step();
    n_vec++; if (awvalid !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid: got %b expected 0", awvalid); end
    n_vec++; if (wvalid !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid: got %b expected 0", wvalid); end
    n_vec++; if (arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid: got %b expected 0", arvalid); end
    n_vec++; if (wb_ack !== 1'b0 || wb_err !== 1'b0) begin n_bad++; $display("FAIL rst_ack_err: got %b%b expected 00", wb_ack, wb_err); end
    n_vec++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", wb_stall); end
    n_vec++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    n_vec++; if (timeout_flag !== 1'b0) begin n_bad++; $display("FAIL rst_flag: got %b expected 0", timeout_flag); end
    n_vec++; if (wb_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h expected 0", wb_rdata); end
    n_vec++; if (bready !== 1'b1 || rready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b%b expected 11", bready, rready); end
    n_vec++; if (awprot !== 3'b000 || arprot !== 3'b000) begin n_bad++; $display("FAIL rst_prot: got %b %b expected 000", awprot, arprot); end
    rst = 1'b0;
    step();
    n_vec++; if (wb_stall !== 1'b0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL post_rst_idle: got stall=%b cnt=%0d expected 0/0", wb_stall, outstanding); end
  endtask

  task automatic test_single_write();
    wb_cyc = 1'b1;
    wb_req(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF);
    #1;
    n_vec++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL wr_stall_idle: got %b expected 0", wb_stall); end
    step();
    wb_stb = 1'b0;
    n_vec++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin n_bad++; $display("FAIL wr_valids: got aw=%b w=%b expected 11", awvalid, wvalid); end
    n_vec++; if (awaddr !== 32'h4) begin n_bad++; $display("FAIL wr_awaddr: got %h expected 00000004", awaddr); end
    n_vec++; if (wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin n_bad++; $display("FAIL wr_data: got %h/%h expected deadbeef/f", wdata, wstrb); end
    n_vec++; if (outstanding !== 3'd1) begin n_bad++; $display("FAIL wr_cnt: got %0d expected 1", outstanding); end
    n_vec++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL wr_stall_pending: got %b expected 1", wb_stall); end
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    n_vec++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin n_bad++; $display("FAIL wr_valids_drop: got aw=%b w=%b expected 00", awvalid, wvalid); end
    bvalid = 1'b1; bresp = 2'b00;
    step();
    bvalid = 1'b0;
    n_vec++; if (wb_ack !== 1'b1 || wb_err !== 1'b0) begin n_bad++; $display("FAIL wr_ack: got ack=%b err=%b expected 1/0", wb_ack, wb_err); end
    n_vec++; if (outstanding !== 3'd0) begin n_bad++; $display("FAIL wr_cnt_done: got %0d expected 0", outstanding); end
    step();
    n_vec++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL wr_ack_pulse: got %b expected 0", wb_ack); end
  endtask

  task automatic test_split_handshake();
    wb_req(1'b1, 32'h0000_0040, 32'h0BADF00D, 4'h5);
    step();
    wb_stb = 1'b0;
    awready = 1'b1;
    step();
    awready = 1'b0;
    n_vec++; if (awvalid !== 1'b0 || wvalid !== 1'b1) begin n_bad++; $display("FAIL split_t2: got aw=%b w=%b expected 0/1", awvalid, wvalid); end
    n_vec++; if (awaddr !== 32'h10 || wstrb !== 4'h5) begin n_bad++; $display("FAIL split_addr: got %h/%h expected 00000010/5", awaddr, wstrb); end
    step();
    n_vec++; if (wvalid !== 1'b1) begin n_bad++; $display("FAIL split_t3: got w=%b expected 1", wvalid); end
    step();
    n_vec++; if (wvalid !== 1'b1) begin n_bad++; $display("FAIL split_t4: got w=%b expected 1", wvalid); end
    wready = 1'b1;
    step();
    wready = 1'b0;
    n_vec++; if (wvalid !== 1'b0 || wb_ack !== 1'b0) begin n_bad++; $display("FAIL split_t5: got w=%b ack=%b expected 0/0", wvalid, wb_ack); end
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    n_vec++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL split_ack: got %b expected 1", wb_ack); end
    step();
    n_vec++; if (wb_ack !== 1'b0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL split_single_ack: got ack=%b cnt=%0d expected 0/0", wb_ack, outstanding); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wb_req(1'b0, 32'(32'h100 + 4 * i), 32'h0, 4'hF);
      wait_accept(ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL b2b_accept%0d: got stalled expected accepted", i); end
      n_vec++; if (arvalid !== 1'b1 || araddr !== 32'(32'h40 + i)) begin n_bad++; $display("FAIL b2b_ar%0d: got v=%b a=%h expected 1/%h", i, arvalid, araddr, 32'(32'h40 + i)); end
      n_vec++; if (outstanding !== 3'(i + 1)) begin n_bad++; $display("FAIL b2b_cnt%0d: got %0d expected %0d", i, outstanding, i + 1); end
    end
    wb_req(1'b0, 32'h200, 32'h0, 4'hF);
    step();
    #1;
    n_vec++; if (wb_stall !== 1'b1 || arvalid !== 1'b0 || outstanding !== 3'd4) begin n_bad++; $display("FAIL b2b_full: got stall=%b arv=%b cnt=%0d expected 1/0/4", wb_stall, arvalid, outstanding); end
    wb_stb = 1'b0;
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rdata = 32'(32'hA0 + i); rresp = 2'b00;
      step();
      n_vec++; if (wb_ack !== 1'b1 || wb_err !== 1'b0 || wb_rdata !== 32'(32'hA0 + i)) begin n_bad++; $display("FAIL b2b_rsp%0d: got ack=%b err=%b d=%h expected 1/0/%h", i, wb_ack, wb_err, wb_rdata, 32'(32'hA0 + i)); end
      n_vec++; if (outstanding !== 3'(3 - i)) begin n_bad++; $display("FAIL b2b_dec%0d: got %0d expected %0d", i, outstanding, 3 - i); end
    end
    rvalid = 1'b0;
    step();
    n_vec++; if (wb_ack !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_end: got %b expected 0", wb_ack); end
  endtask

  task automatic test_dir_block();
    bit ok;
    arready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wb_req(1'b0, 32'(32'h300 + 4 * i), 32'h0, 4'hF);
      wait_accept(ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL dir_rd_accept%0d: got stalled expected accepted", i); end
    end
    step();
    arready = 1'b0;
    wb_req(1'b1, 32'h20, 32'h12345678, 4'h3);
    #1;
    n_vec++; if (wb_stall !== 1'b1) begin n_bad++; $display("FAIL dir_stall2: got %b expected 1", wb_stall); end
    rvalid = 1'b1; rdata = 32'hB0;
    step();
    n_vec++; if (wb_stall !== 1'b1 || outstanding !== 3'd1) begin n_bad++; $display("FAIL dir_stall1: got stall=%b cnt=%0d expected 1/1", wb_stall, outstanding); end
    rdata = 32'hB1;
    step();
    rvalid = 1'b0;
    #1;
    n_vec++; if (wb_stall !== 1'b0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL dir_release: got stall=%b cnt=%0d expected 0/0", wb_stall, outstanding); end
    step();
    wb_stb = 1'b0;
    n_vec++; if (awvalid !== 1'b1 || awaddr !== 32'h8 || wstrb !== 4'h3 || outstanding !== 3'd1) begin n_bad++; $display("FAIL dir_wr_issued: got v=%b a=%h s=%h cnt=%0d expected 1/8/3/1", awvalid, awaddr, wstrb, outstanding); end
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    n_vec++; if (wb_ack !== 1'b1) begin n_bad++; $display("FAIL dir_wr_ack: got %b expected 1", wb_ack); end
    step();
  endtask

  task automatic test_bresp_error();
    wb_req(1'b1, 32'h30, 32'h0000CAFE, 4'hF);
    step();
    wb_stb = 1'b0;
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b10;
    step();
    bvalid = 1'b0; bresp = 2'b00;
    n_vec++; if (wb_err !== 1'b1 || wb_ack !== 1'b0) begin n_bad++; $display("FAIL bresp_err: got err=%b ack=%b expected 1/0", wb_err, wb_ack); end
    step();
    n_vec++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL bresp_err_pulse: got %b expected 0", wb_err); end
  endtask

  task automatic test_abandoned();
    wb_req(1'b0, 32'h50, 32'h0, 4'hF);
    step();
    wb_stb = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    wb_cyc = 1'b0;
    rvalid = 1'b1; rdata = 32'h77;
    step();
    rvalid = 1'b0;
    n_vec++; if (wb_ack !== 1'b0 || wb_err !== 1'b0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL abandon: got ack=%b err=%b cnt=%0d expected 0/0/0", wb_ack, wb_err, outstanding); end
    wb_cyc = 1'b1;
    step();
  endtask

  task automatic test_same_cycle();
    wb_req(1'b0, 32'h60, 32'h0, 4'hF);
    step();
    wb_stb = 1'b0;
    arready = 1'b1;
    step();
    wb_req(1'b0, 32'h64, 32'h0, 4'hF);
    rvalid = 1'b1; rdata = 32'hC0;
    #1;
    n_vec++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL same_stall: got %b expected 0", wb_stall); end
    step();
    wb_stb = 1'b0;
    rvalid = 1'b0;
    n_vec++; if (outstanding !== 3'd1 || wb_ack !== 1'b1 || wb_rdata !== 32'hC0) begin n_bad++; $display("FAIL same_cycle: got cnt=%0d ack=%b d=%h expected 1/1/c0", outstanding, wb_ack, wb_rdata); end
    n_vec++; if (arvalid !== 1'b1 || araddr !== 32'h19) begin n_bad++; $display("FAIL same_ar: got v=%b a=%h expected 1/19", arvalid, araddr); end
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hC1;
    step();
    rvalid = 1'b0;
    n_vec++; if (wb_ack !== 1'b1 || wb_rdata !== 32'hC1 || outstanding !== 3'd0) begin n_bad++; $display("FAIL same_second: got ack=%b d=%h cnt=%0d expected 1/c1/0", wb_ack, wb_rdata, outstanding); end
    step();
  endtask

  task automatic test_timeout();
    bit ok;
    int first = -1;
    int nerr = 0;
    int run = 0;
    int maxrun = 0;
    bit any_ack = 0;
    logic stall_at_err = 1'b0;
    arready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_req(1'b0, 32'(32'h400 + 4 * i), 32'h0, 4'hF);
      wait_accept(ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL tmo_accept%0d: got stalled expected accepted", i); end
    end
    for (int k = 1; k <= 40; k++) begin
      if (wb_ack) any_ack = 1'b1;
      if (wb_err) begin
        if (first < 0) begin
          first = k;
          stall_at_err = wb_stall;
        end
        nerr++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      step();
    end
    arready = 1'b0;
    n_vec++; if (first < 16 || first > 20) begin n_bad++; $display("FAIL tmo_first_err: got cycle %0d expected 16..20", first); end
    n_vec++; if (nerr != 3 || maxrun != 3) begin n_bad++; $display("FAIL tmo_err_count: got %0d (run %0d) expected 3 consecutive", nerr, maxrun); end
    n_vec++; if (stall_at_err !== 1'b1) begin n_bad++; $display("FAIL tmo_abort_stall: got %b expected 1", stall_at_err); end
    n_vec++; if (any_ack) begin n_bad++; $display("FAIL tmo_no_ack: got ack during abort expected none"); end
    n_vec++; if (outstanding !== 3'd0 || timeout_flag !== 1'b1 || arvalid !== 1'b0) begin n_bad++; $display("FAIL tmo_end: got cnt=%0d flag=%b arv=%b expected 0/1/0", outstanding, timeout_flag, arvalid); end
    rvalid = 1'b1; rdata = 32'hEE;
    step();
    rvalid = 1'b0;
    n_vec++; if (wb_ack !== 1'b0 || wb_err !== 1'b0 || outstanding !== 3'd0 || timeout_flag !== 1'b1) begin n_bad++; $display("FAIL tmo_late_rsp: got ack=%b err=%b cnt=%0d flag=%b expected 0/0/0/1", wb_ack, wb_err, outstanding, timeout_flag); end
    #1;
    n_vec++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL tmo_idle_stall: got %b expected 0", wb_stall); end
  endtask

  task automatic test_reset_mid();
    wb_req(1'b0, 32'h500, 32'h0, 4'hF);
    step();
    wb_stb = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (arvalid !== 1'b0 || outstanding !== 3'd0 || timeout_flag !== 1'b0) begin n_bad++; $display("FAIL rstmid: got arv=%b cnt=%0d flag=%b expected 0/0/0", arvalid, outstanding, timeout_flag); end
    rvalid = 1'b1; rdata = 32'h55;
    step();
    rvalid = 1'b0;
    n_vec++; if (wb_ack !== 1'b0 || wb_err !== 1'b0 || outstanding !== 3'd0) begin n_bad++; $display("FAIL rstmid_late: got ack=%b err=%b cnt=%0d expected 0/0/0", wb_ack, wb_err, outstanding); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit, expected summary before it");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_split_handshake();
    test_back_to_back();
    test_dir_block();
    test_bresp_error();
    test_abandoned();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
